// File: rtl/inst_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction queue.
// Fetch and decode drive the master side; the queue uses the slave side.
interface inst_queue_if #(
    parameter int MIP_BUS = 16,
    parameter int DEPTH   = 4
);
    logic                   in_valid;
    logic [MIP_BUS-1:0]     in_pc;
    logic [31:0]            in_inst;
    logic                   in_ready;
    logic                   flush;
    logic                   out_valid;
    logic [MIP_BUS-1:0]     out_pc;
    logic [31:0]            out_inst;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] count;

    modport master (
        output in_valid, in_pc, in_inst, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, count
    );

    modport slave (
        input  in_valid, in_pc, in_inst, flush, out_ready,
        output in_ready, out_valid, out_pc, out_inst, count
    );
endinterface

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: a FIFO of {pc, inst} pairs.
// Handshake outputs depend on registered state only; the head reads as a NOP when empty.
module inst_queue #(
    parameter int MIP_BUS = 16,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    inst_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [MIP_BUS-1:0] pc_mem_q   [DEPTH];
    logic [31:0]        inst_mem_q [DEPTH];
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               in_ready_s, out_valid_s, push_s, pop_s;

    assign in_ready_s  = (count_q != FULL_CNT);
    assign out_valid_s = (count_q != {CW{1'b0}});
    assign push_s      = q.in_valid & in_ready_s & ~q.flush;
    assign pop_s       = out_valid_s & q.out_ready & ~q.flush;

    // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (q.flush) begin
            rd_ptr_d = {PW{1'b0}};
            wr_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is left unreset; an entry is only visible once counted
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_q[wr_ptr_q]   <= q.in_pc;
            inst_mem_q[wr_ptr_q] <= q.in_inst;
        end
    end

    assign q.in_ready  = in_ready_s;
    assign q.out_valid = out_valid_s;
    assign q.out_pc    = out_valid_s ? pc_mem_q[rd_ptr_q]   : {MIP_BUS{1'b0}};
    assign q.out_inst  = out_valid_s ? inst_mem_q[rd_ptr_q] : 32'h0000_0000;
    assign q.count     = count_q;
endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_inst_queue;
    localparam int MIP_BUS = 16;
    localparam int DEPTH   = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [MIP_BUS+31:0] mq[$];

    inst_queue_if #(.MIP_BUS(MIP_BUS), .DEPTH(DEPTH)) ifc ();

    inst_queue #(.MIP_BUS(MIP_BUS), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .q   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every visible output to the reference model
    task automatic compare_model(input string tag);
        logic [MIP_BUS-1:0] e_pc;
        logic [31:0]        e_inst;
        int                 sz;
        sz     = mq.size();
        e_pc   = (sz != 0) ? mq[0][MIP_BUS+31:32] : '0;
        e_inst = (sz != 0) ? mq[0][31:0] : 32'h0;
        check({tag, ".count"},     64'(ifc.count),     64'(sz));
        check({tag, ".out_valid"}, 64'(ifc.out_valid), 64'(sz != 0));
        check({tag, ".in_ready"},  64'(ifc.in_ready),  64'(sz != DEPTH));
        check({tag, ".out_pc"},    64'(ifc.out_pc),    64'(e_pc));
        check({tag, ".out_inst"},  64'(ifc.out_inst),  64'(e_inst));
    endtask

    // One clock cycle: drive at the falling edge, update the model at the edge, compare after
    task automatic cyc(input logic v, input logic [MIP_BUS-1:0] pc, input logic [31:0] inst,
                       input logic fl, input logic ordy, input logic rs, input string tag);
        logic do_push, do_pop;
        ifc.in_valid  = v;
        ifc.in_pc     = pc;
        ifc.in_inst   = inst;
        ifc.flush     = fl;
        ifc.out_ready = ordy;
        rst           = rs;
        do_push = v && (mq.size() < DEPTH);
        do_pop  = ordy && (mq.size() > 0);
        @(posedge clk);
        if (rs || fl) begin
            mq.delete();
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back({pc, inst});
        end
        @(negedge clk);
        compare_model(tag);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        ifc.in_valid = 1'b0; ifc.in_pc = '0; ifc.in_inst = 32'h0;
        ifc.flush = 1'b0; ifc.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        mq.delete();
        @(negedge clk);
        cyc(1'b0, '0, 32'h0, 1'b0, 1'b0, 1'b1, "reset");
        check("reset.in_ready", 64'(ifc.in_ready), 64'd1);
        check("reset.out_inst", 64'(ifc.out_inst), 64'd0);

        // Basic flow
        cyc(1'b1, 16'h0000, 32'h2001_0005, 1'b0, 1'b0, 1'b0, "basic");
        check("basic.out_inst", 64'(ifc.out_inst), 64'h2001_0005);
        check("basic.count", 64'(ifc.count), 64'd1);
        cyc(1'b0, '0, 32'h0, 1'b0, 1'b0, 1'b1, "basic_rst");

        // Fill, drop fifth push, drain in order
        for (int i = 1; i <= 4; i++)
            cyc(1'b1, MIP_BUS'(i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 1'b0, "fill");
        check("fill.count", 64'(ifc.count), 64'd4);
        check("fill.in_ready", 64'(ifc.in_ready), 64'd0);
        cyc(1'b1, 16'h0005, 32'hA000_0005, 1'b0, 1'b0, 1'b0, "fill_drop");
        check("fill_drop.count", 64'(ifc.count), 64'd4);
        for (int i = 1; i <= 4; i++) begin
            check("drain.out_pc", 64'(ifc.out_pc), 64'(i));
            cyc(1'b0, '0, 32'h0, 1'b0, 1'b1, 1'b0, "drain");
        end
        check("drain.empty", 64'(ifc.out_valid), 64'd0);

        // Full plus pop, then simultaneous push and pop
        for (int i = 1; i <= 4; i++)
            cyc(1'b1, 16'h0010 + MIP_BUS'(i), 32'hB000_0000 + 32'(i), 1'b0, 1'b0, 1'b0, "refill");
        cyc(1'b1, 16'h0020, 32'hB000_0020, 1'b0, 1'b1, 1'b0, "fullpop");
        check("fullpop.count", 64'(ifc.count), 64'd3);
        check("fullpop.out_pc", 64'(ifc.out_pc), 64'h12);
        cyc(1'b1, 16'h0021, 32'hB000_0021, 1'b0, 1'b1, 1'b0, "pushpop");
        check("pushpop.count", 64'(ifc.count), 64'd3);
        check("pushpop.out_pc", 64'(ifc.out_pc), 64'h13);

        // Flush with push and pop requested
        cyc(1'b1, 16'h0030, 32'hC000_0030, 1'b1, 1'b1, 1'b0, "flush");
        check("flush.count", 64'(ifc.count), 64'd0);
        check("flush.out_inst", 64'(ifc.out_inst), 64'd0);
        check("flush.in_ready", 64'(ifc.in_ready), 64'd1);

        // Empty pops leave pointers alone
        for (int i = 0; i < 3; i++)
            cyc(1'b0, '0, 32'h0, 1'b0, 1'b1, 1'b0, "emptypop");
        cyc(1'b1, 16'h0040, 32'hD000_0040, 1'b0, 1'b0, 1'b0, "after_empty");
        check("after_empty.out_pc", 64'(ifc.out_pc), 64'h40);
        check("after_empty.count", 64'(ifc.count), 64'd1);

        // Reset mid-stream
        cyc(1'b1, 16'h0041, 32'hD000_0041, 1'b0, 1'b0, 1'b0, "pre_rst");
        check("pre_rst.count", 64'(ifc.count), 64'd2);
        cyc(1'b1, 16'h0042, 32'hD000_0042, 1'b1, 1'b1, 1'b1, "midrst");
        check("midrst.count", 64'(ifc.count), 64'd0);
        check("midrst.out_valid", 64'(ifc.out_valid), 64'd0);
        cyc(1'b1, 16'h0010, 32'hE000_0010, 1'b0, 1'b0, 1'b0, "post_rst");
        check("post_rst.out_pc", 64'(ifc.out_pc), 64'h10);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 99) < 65), MIP_BUS'($urandom), $urandom,
                1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 99) < 50),
                1'($urandom_range(0, 99) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
